// File: rtl/ps2_scan_ctrl.sv
// PS/2 keyboard receiver: decodes scan codes with E0/F0 prefixes into a FWFT FIFO.
// Entry visible 3 CLOCK_50 edges after the stop-bit fall; when full a new entry is dropped and fifo_ovf sticks.
module ps2_scan_ctrl #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } entry_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall, sdat;
    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [CW-1:0] idle_cnt;
    logic          timeout, byte_ok, byte_bad, push;
    logic          ext_flag, brk_flag;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en, drop;
    entry_t        head;

    // Reset high so the edge detector never sees a fall right after reset release
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign sdat    = dat_sync[1];
    assign timeout = (state != IDLE) && !fall && (idle_cnt == TO_LAST);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!sdat) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Odd parity over data plus parity bit, and a high stop bit, accept the byte
    always_comb begin
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (fall && state == STOP) begin
            if (sdat && (^{shreg, par_bit})) byte_ok  = 1'b1;
            else                             byte_bad = 1'b1;
        end
    end

    assign push = byte_ok && (shreg != 8'hE0) && (shreg != 8'hF0);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            frame_err <= byte_bad | timeout;
            if (state == IDLE || fall || timeout) idle_cnt <= '0;
            else                                  idle_cnt <= idle_cnt + CW'(1);
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {sdat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit <= sdat;
                    default: ;
                endcase
            end
            if (timeout) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

    assign full      = (count == FULL_CNT);
    assign key_valid = (count != '0);
    assign pop       = key_valid & key_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_ptr] <= '{ext: ext_flag, brk: brk_flag, code: shreg};
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !wr_en) count <= count - (AW+1)'(1);
            if (drop) fifo_ovf <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign key_code  = key_valid ? head.code : 8'h00;
    assign key_break = key_valid ? head.brk  : 1'b0;
    assign key_ext   = key_valid ? head.ext  : 1'b0;

endmodule
